// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative MIPS DIV/DIVU divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The full partial remainder is kept in the shift so divisors above 2^(WIDTH-1) still divide correctly;
  // the difference always fits WIDTH+1 signed bits, so its top bit is the borrow.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[WIDTH];
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; result packed as {remainder, quotient} for HI/LO.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               valid,
  input  logic               sign,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // The result is registered on the final iteration edge so it is already stable in the ready cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    ready_d  = 1'b0;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            dvd_d   = (sign && a[WIDTH-1]) ? -a : a;
            dvs_d   = (sign && b[WIDTH-1]) ? -b : b;
            q_neg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_d = sign & a[WIDTH-1];
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          quo_d = {quo_q[WIDTH-2:0], step_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {r_neg_q ? -step_rem : step_rem,
                        q_neg_q ? -quo_d    : quo_d};
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results, divide-by-zero, flush and async reset.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        sign;
  logic        ready;
  logic [63:0] result;

  int checks;
  int errors;
  logic [63:0] last_expected;

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .sign   (sign),
    .ready  (ready),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one start pulse; returns #1 after the edge that samples it.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a     = av;
    b     = bv;
    sign  = sv;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Counts cycles from the valid cycle until ready; a timeout returns max_cyc+1.
  task automatic wait_ready(input int max_cyc, output int cyc);
    cyc = 1;
    while (!ready && cyc <= max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [63:0] exp_res);
    int cyc;
    start_op(av, bv, sv);
    wait_ready(60, cyc);
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected 33", name, cyc);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("[TB] FAIL %s result: got %h, expected %h", name, result, exp_res);
    end
    last_expected = exp_res;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s ready pulse width: ready=%b one cycle later, expected 0", name, ready);
    end
  endtask

  // Watches n cycles and reports how many of them had ready high.
  task automatic count_ready(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset ready: got %b, expected 0", ready);
    end
    checks++;
    if (result !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset result: got %h, expected 0", result);
    end
    rst = 1'b0;
    last_expected = 64'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned;
    run_op("u_7_2",        32'd7,        32'd2,        1'b0, 64'h00000001_00000003);
    run_op("u_fff9_2",     32'hFFFFFFF9, 32'h2,        1'b0, 64'h00000001_7FFFFFFC);
    run_op("u_big_divisor", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 64'h00000001_00000001);
  endtask

  task automatic test_signed;
    run_op("s_m7_2",  32'hFFFFFFF9, 32'h2,        1'b1, 64'hFFFFFFFF_FFFFFFFD);
    run_op("s_7_m2",  32'h7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD);
    run_op("s_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_00000003);
  endtask

  task automatic test_div_zero;
    run_op("u_5_0",        32'd5,        32'd0,        1'b0, 64'h00000005_FFFFFFFF);
    run_op("s_m5_0",       32'hFFFFFFFB, 32'd0,        1'b1, 64'hFFFFFFFB_00000001);
    run_op("s_min_m1",     32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
  endtask

  task automatic test_flush;
    int seen;
    start_op(32'd9, 32'd4, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    count_ready(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL flush_busy ready: seen %0d ready cycles, expected 0", seen);
    end
    checks++;
    if (result !== last_expected) begin
      errors++;
      $display("[TB] FAIL flush_busy result: got %h, expected %h", result, last_expected);
    end
    run_op("u_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
  endtask

  task automatic test_valid_during_busy;
    int cyc;
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a     = 32'd50;
    b     = 32'd3;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    cyc = 6;
    while (!ready && cyc <= 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("[TB] FAIL busy_valid latency: got %0d cycles, expected 33", cyc);
    end
    checks++;
    if (result !== 64'h00000000_00000064) begin
      errors++;
      $display("[TB] FAIL busy_valid result: got %h, expected %h", result, 64'h00000000_00000064);
    end
    last_expected = 64'h00000000_00000064;
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_flush_same;
    int seen;
    @(negedge clk);
    a     = 32'd20;
    b     = 32'd3;
    sign  = 1'b0;
    valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    count_ready(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL valid_flush ready: seen %0d ready cycles, expected 0", seen);
    end
    checks++;
    if (result !== last_expected) begin
      errors++;
      $display("[TB] FAIL valid_flush result: got %h, expected %h", result, last_expected);
    end
  endtask

  task automatic test_async_reset;
    int seen;
    start_op(32'd77, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 64'h0) begin
      errors++;
      $display("[TB] FAIL async_rst result: got %h, expected 0", result);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_rst ready: got %b, expected 0", ready);
    end
    #2;
    rst = 1'b0;
    last_expected = 64'h0;
    count_ready(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL async_rst idle: seen %0d ready cycles, expected 0", seen);
    end
    run_op("u_ffff_10", 32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_valid_during_busy();
    test_valid_flush_same();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
